// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: width codes, FSM states
// and the access-size / byte-mask tables.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] W_WORD  = 3'b000;
  localparam logic [2:0] W_HALF  = 3'b010;
  localparam logic [2:0] W_BYTE  = 3'b001;
  localparam logic [2:0] W_HALFU = 3'b110;
  localparam logic [2:0] W_BYTEU = 3'b101;

  function automatic logic width_legal(input logic [2:0] code);
    case (code)
      W_WORD, W_HALF, W_BYTE, W_HALFU, W_BYTEU: width_legal = 1'b1;
      default:                                  width_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] width_size(input logic [2:0] code);
    case (code)
      W_HALF, W_HALFU: width_size = 3'd2;
      W_BYTE, W_BYTEU: width_size = 3'd1;
      default:         width_size = 3'd4;
    endcase
  endfunction

  function automatic logic width_signed(input logic [2:0] code);
    case (code)
      W_HALF, W_BYTE: width_signed = 1'b1;
      default:        width_signed = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] size);
    case (size)
      3'd4:    size_mask = 4'b1111;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for both beats and load-data extraction
// with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [3:0]  be1,
  output logic [3:0]  be2,
  output logic [31:0] wd1,
  output logic [31:0] wd2,
  output logic [31:0] rdata
);

  logic [2:0]  rem;
  logic [7:0]  mask_wide;
  logic [31:0] low;

  // lane steering and load extraction
  always_comb begin
    rem       = 3'd4 - {1'b0, off};
    mask_wide = {4'b0000, size_mask(size)} << off;
    be1       = mask_wide[3:0];
    be2       = size_mask(size) >> rem;
    wd1       = wdata << {off, 3'b000};
    wd2       = wdata >> {rem, 3'b000};
    low       = 32'({rd_hi, rd_lo} >> {off, 3'b000});
    case (size)
      3'd2:    rdata = sign_ext ? {{16{low[15]}}, low[15:0]} : {16'h0000, low[15:0]};
      3'd1:    rdata = sign_ext ? {{24{low[7]}}, low[7:0]} : {24'h000000, low[7:0]};
      default: rdata = low;
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Splits a pipeline load/store of any alignment into one or two word-aligned
// memory beats and returns extended load data as a single-cycle response.
module load_store_sequencer
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [2:0]  WidthSrc,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        ReqReady,
  output logic        Stall,
  output logic        RespValid,
  output logic [31:0] RespRData,
  output logic        RespErr,
  output logic        MemValid,
  input  logic        MemReady,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  input  logic [31:0] MemRData
);

  state_t      state_r, state_s;
  logic [31:0] addr_r, data_r, beat1_r, rdata_r;
  logic [2:0]  size_r;
  logic        sext_r, write_r, err_r;
  logic        split_s, accept_s;
  logic [31:0] word_addr_s, rd_lo_s, rd_hi_s, load_s, wd1_s, wd2_s;
  logic [3:0]  be1_s, be2_s;

  assign accept_s    = (state_r == IDLE) && ReqValid;
  assign split_s     = ({1'b0, addr_r[1:0]} + size_r) > 3'd4;
  assign word_addr_s = {addr_r[31:2], 2'b00};
  // beat data is folded in the cycle it completes so the result can be registered
  assign rd_lo_s     = (state_r == BEAT1) ? MemRData : beat1_r;
  assign rd_hi_s     = (state_r == BEAT2) ? MemRData : 32'h0000_0000;

  lsu_align u_align (
    .size     (size_r),
    .off      (addr_r[1:0]),
    .sign_ext (sext_r),
    .wdata    (data_r),
    .rd_lo    (rd_lo_s),
    .rd_hi    (rd_hi_s),
    .be1      (be1_s),
    .be2      (be2_s),
    .wd1      (wd1_s),
    .wd2      (wd2_s),
    .rdata    (load_s)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ReqValid) state_s = width_legal(WidthSrc) ? BEAT1 : RESP;
        else          state_s = IDLE;
      end
      BEAT1: begin
        if (MemReady) state_s = split_s ? BEAT2 : RESP;
        else          state_s = BEAT1;
      end
      BEAT2: begin
        if (MemReady) state_s = RESP;
        else          state_s = BEAT2;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // request capture and read-data accumulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r  <= 32'h0000_0000;
      data_r  <= 32'h0000_0000;
      beat1_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
      size_r  <= 3'd4;
      sext_r  <= 1'b0;
      write_r <= 1'b0;
      err_r   <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= ReqAddr;
      data_r  <= ReqWrite ? ReqWData : 32'h0000_0000;
      beat1_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
      size_r  <= width_size(WidthSrc);
      sext_r  <= width_signed(WidthSrc);
      write_r <= ReqWrite;
      err_r   <= !width_legal(WidthSrc);
    end else if ((state_r == BEAT1) && MemReady) begin
      beat1_r <= MemRData;
      if (!split_s && !write_r) rdata_r <= load_s;
    end else if ((state_r == BEAT2) && MemReady && !write_r) begin
      rdata_r <= load_s;
    end
  end

  // handshake and memory-beat outputs decoded from registered state
  always_comb begin
    ReqReady  = (state_r == IDLE);
    Stall     = accept_s || (state_r == BEAT1) || (state_r == BEAT2);
    RespValid = (state_r == RESP);
    RespErr   = (state_r == RESP) && err_r;
    RespRData = rdata_r;
    MemValid  = 1'b0;
    MemWrite  = 1'b0;
    MemAddr   = 32'h0000_0000;
    MemWData  = 32'h0000_0000;
    MemByteEn = 4'b0000;
    case (state_r)
      BEAT1: begin
        MemValid  = 1'b1;
        MemWrite  = write_r;
        MemAddr   = word_addr_s;
        MemWData  = wd1_s;
        MemByteEn = be1_s;
      end
      BEAT2: begin
        MemValid  = 1'b1;
        MemWrite  = write_r;
        MemAddr   = word_addr_s + 32'd4;
        MemWData  = wd2_s;
        MemByteEn = be2_s;
      end
      default: begin
        MemValid  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer: expected responses are queued at
// issue time and compared when the sequencer pulses RespValid.
module tb_load_store_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid, ReqWrite;
  logic [2:0]  WidthSrc;
  logic [31:0] ReqAddr, ReqWData;
  logic        ReqReady, Stall, RespValid, RespErr;
  logic [31:0] RespRData;
  logic        MemValid, MemReady, MemWrite;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic [3:0]  MemByteEn;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  load_store_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .ReqValid  (ReqValid),
    .ReqWrite  (ReqWrite),
    .WidthSrc  (WidthSrc),
    .ReqAddr   (ReqAddr),
    .ReqWData  (ReqWData),
    .ReqReady  (ReqReady),
    .Stall     (Stall),
    .RespValid (RespValid),
    .RespRData (RespRData),
    .RespErr   (RespErr),
    .MemValid  (MemValid),
    .MemReady  (MemReady),
    .MemWrite  (MemWrite),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemByteEn (MemByteEn),
    .MemRData  (MemRData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single cycle starting at a negedge; optionally queue its response.
  task automatic issue(input logic wr, input logic [2:0] code, input logic [31:0] addr,
                       input logic [31:0] wd, input logic push, input logic [31:0] exp_rd,
                       input logic exp_err);
    resp_t e;
    ReqValid = 1'b1;
    ReqWrite = wr;
    WidthSrc = code;
    ReqAddr  = addr;
    ReqWData = wd;
    #1;
    chk("req_ready_idle", {31'd0, ReqReady}, 32'd1);
    chk("stall_on_accept", {31'd0, Stall}, 32'd1);
    if (push) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb.push_back(e);
    end
    @(negedge clk);
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    WidthSrc = 3'b000;
    ReqAddr  = 32'h0;
    ReqWData = 32'h0;
  endtask

  // Serve one memory beat: check its fields, optionally hold MemReady low, then complete it.
  task automatic beat(input logic [31:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] exp_wd, input logic exp_wr,
                      input logic [31:0] rd, input int hold);
    int n = 0;
    while (MemValid !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("beat_delay", n, 32'd0);
    chk("mem_valid", {31'd0, MemValid}, 32'd1);
    chk("mem_addr", MemAddr, exp_addr);
    chk("mem_byteen", {28'd0, MemByteEn}, {28'd0, exp_be});
    chk("mem_write", {31'd0, MemWrite}, {31'd0, exp_wr});
    if (exp_wr) chk("mem_wdata", MemWData, exp_wd);
    chk("req_ready_busy", {31'd0, ReqReady}, 32'd0);
    MemRData = rd;
    for (int i = 0; i < hold; i++) begin
      MemReady = 1'b0;
      @(negedge clk);
      chk("hold_valid", {31'd0, MemValid}, 32'd1);
      chk("hold_addr", MemAddr, exp_addr);
      chk("hold_byteen", {28'd0, MemByteEn}, {28'd0, exp_be});
      if (exp_wr) chk("hold_wdata", MemWData, exp_wd);
      chk("hold_stall", {31'd0, Stall}, 32'd1);
    end
    MemReady = 1'b1;
    @(negedge clk);
    MemReady = 1'b0;
    MemRData = 32'h0;
  endtask

  // Wait (bounded) for the response pulse and compare it against the scoreboard head.
  task automatic wait_resp(input int exp_lat);
    resp_t e;
    int n = 0;
    while (RespValid !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("resp_latency", n, exp_lat);
    chk("resp_valid", {31'd0, RespValid}, 32'd1);
    chk("resp_stall", {31'd0, Stall}, 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_rdata", RespRData, e.rdata);
      chk("resp_err", {31'd0, RespErr}, {31'd0, e.err});
    end else begin
      mismatched++;
      $error("FAIL resp_unexpected: observed response with empty scoreboard, expected none");
    end
    @(negedge clk);
    chk("resp_one_cycle", {31'd0, RespValid}, 32'd0);
    chk("idle_ready", {31'd0, ReqReady}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    WidthSrc = 3'b000;
    ReqAddr  = 32'h0;
    ReqWData = 32'h0;
    MemReady = 1'b0;
    MemRData = 32'h0;
    #1;
    chk("rst_mem_valid", {31'd0, MemValid}, 32'd0);
    chk("rst_resp_valid", {31'd0, RespValid}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_rdata", RespRData, 32'd0);
    chk("rst_addr", MemAddr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ReqReady}, 32'd1);

    // aligned lw
    issue(1'b0, 3'b000, 32'h0000_0100, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    beat(32'h0000_0100, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF, 0);
    wait_resp(0);

    // lb / lbu at byte 3
    issue(1'b0, 3'b001, 32'h0000_0103, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
    beat(32'h0000_0100, 4'b1000, 32'h0, 1'b0, 32'h8012_3456, 0);
    wait_resp(0);
    issue(1'b0, 3'b101, 32'h0000_0103, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
    beat(32'h0000_0100, 4'b1000, 32'h0, 1'b0, 32'h8012_3456, 0);
    wait_resp(0);

    // split sw
    issue(1'b1, 3'b000, 32'h0000_0202, 32'h1122_3344, 1'b1, 32'h0, 1'b0);
    beat(32'h0000_0200, 4'b1100, 32'h3344_0000, 1'b1, 32'h5555_5555, 0);
    beat(32'h0000_0204, 4'b0011, 32'h0000_1122, 1'b1, 32'h6666_6666, 0);
    wait_resp(0);

    // split lh wrapping the address space
    issue(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'hFFFF_8012, 1'b0);
    beat(32'hFFFF_FFFC, 4'b1000, 32'h0, 1'b0, 32'h1234_5678, 0);
    beat(32'h0000_0000, 4'b0001, 32'h0, 1'b0, 32'hAABB_CC80, 0);
    wait_resp(0);

    // unaligned non-split lh
    issue(1'b0, 3'b010, 32'h0000_0101, 32'h0, 1'b1, 32'hFFFF_ABCD, 1'b0);
    beat(32'h0000_0100, 4'b0110, 32'h0, 1'b0, 32'h00AB_CD00, 0);
    wait_resp(0);

    // sb with unsigned code behaves as plain byte store
    issue(1'b1, 3'b101, 32'h0000_0001, 32'h0000_00A5, 1'b1, 32'h0, 1'b0);
    beat(32'h0000_0000, 4'b0010, 32'h0000_A500, 1'b1, 32'h7777_7777, 0);
    wait_resp(0);

    // illegal width code
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0, 1'b1, 32'h0, 1'b1);
    chk("err_no_mem", {31'd0, MemValid}, 32'd0);
    wait_resp(0);

    // stalled beat1, then reset during beat2: transaction abandoned
    issue(1'b1, 3'b000, 32'h0000_0202, 32'h1122_3344, 1'b0, 32'h0, 1'b0);
    beat(32'h0000_0200, 4'b1100, 32'h3344_0000, 1'b1, 32'h0, 5);
    chk("b2_valid", {31'd0, MemValid}, 32'd1);
    chk("b2_addr", MemAddr, 32'h0000_0204);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, MemValid}, 32'd0);
    chk("rst_mid_addr", MemAddr, 32'd0);
    chk("rst_mid_byteen", {28'd0, MemByteEn}, 32'd0);
    chk("rst_mid_wdata", MemWData, 32'd0);
    chk("rst_mid_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_resp_after_rst", {31'd0, RespValid}, 32'd0);
    end

    // recovery: lhu upper half
    issue(1'b0, 3'b110, 32'h0000_0102, 32'h0, 1'b1, 32'h0000_8001, 1'b0);
    beat(32'h0000_0100, 4'b1100, 32'h0, 1'b0, 32'h8001_1234, 0);
    wait_resp(0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
